mem_io_responder: RTL and testbench

Byte-wide memory responder on the RAM side of the memory controller's ram bus (`signal_to_ram`, `addr_to_ram`, `data_to_ram` in; `data_from_ram`, `uart_full_signal` out). It serves one byte access per cycle from on-chip RAM and decodes an I/O window at the top of the address space into a UART TX FIFO, a single-byte RX holding register, a status byte and a halt flag. Read data is registered and returned exactly one cycle after the address, matching the controller's fetch/load sequencing.

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_if.sv | 20 ++
 rtl/mem_io_responder_byte_ram.sv | 26 ++
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the RAM-side memory responder.
package mem_io_responder_pkg;

  localparam int ADDR_W      = 18;
  localparam int BYTE_W      = 8;
  localparam int IO_BIT      = 17;
  localparam int IO_SEL_BIT  = 2;
  localparam int IO_DATA_SEL = 0;
  localparam int IO_STAT_SEL = 1;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_DATA,
    SEL_STAT
  } sel_e;

  // Only the I/O flag and the port-select bit take part in the decode.
  function automatic sel_e decode(input logic io, input logic port_bit);
    if (!io)                           return SEL_RAM;
    else if (port_bit == 1'(IO_DATA_SEL)) return SEL_DATA;
    else                               return SEL_STAT;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide ram bus between the memory controller (master) and the responder (slave).
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic              mem_wr;
  logic [ADDR_W-1:0] mem_a;
  logic [BYTE_W-1:0] mem_din;
  logic [BYTE_W-1:0] mem_dout;
  logic              io_full;

  modport master (
    output mem_wr, mem_a, mem_din,
    input  mem_dout, io_full
  );

  modport slave (
    input  mem_wr, mem_a, mem_din,
    output mem_dout, io_full
  );
endinterface

// File: rtl/mem_io_responder_byte_ram.sv
// Single-port synchronous byte RAM with registered read.
module byte_ram
  import mem_io_responder_pkg::*;
#(
  parameter int    AW        = 17,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] mem [2**AW];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// RAM-side responder: on-chip RAM plus an I/O window with a TX FIFO, RX holding byte,
// status byte and sticky halt flag. Read data returns one cycle after the address.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    RAM_AW    = 17,
  parameter int    TX_DEPTH  = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  mem_io_responder_if.slave   bus,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                halt
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  sel_e              sel;
  logic              ram_we;
  logic [BYTE_W-1:0] ram_dout;

  logic [BYTE_W-1:0] fifo_mem [TX_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              io_full;
  logic              push_req;
  logic              push;
  logic              pop;

  logic              rx_full;
  logic [BYTE_W-1:0] rx_byte;
  logic              data_rd;

  logic [BYTE_W-1:0] io_rdata;
  logic [BYTE_W-1:0] io_q;
  logic              dout_from_ram;

  assign sel = decode(bus.mem_a[IO_BIT], bus.mem_a[IO_SEL_BIT]);

  // ---------------------------------------------------------------- RAM
  assign ram_we = rdy && !rst && (sel == SEL_RAM) && bus.mem_wr;

  byte_ram #(
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .en   (rdy),
    .we   (ram_we),
    .addr (bus.mem_a[RAM_AW-1:0]),
    .din  (bus.mem_din),
    .dout (ram_dout)
  );

  // ------------------------------------------------------------ TX FIFO
  assign io_full  = (count == CW'(TX_DEPTH));
  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? fifo_mem[head] : '0;
  assign push_req = rdy && (sel == SEL_DATA) && bus.mem_wr;
  assign pop      = rdy && tx_valid && tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push     = push_req && (!io_full || pop);

  // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------------- RX
  assign data_rd  = rdy && (sel == SEL_DATA) && !bus.mem_wr;
  assign rx_ready = !rx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_byte <= '0;
    end else if (data_rd && rx_full) begin
      rx_full <= 1'b0;
    end else if (rdy && rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_byte <= rx_data;
    end
  end

  // ----------------------------------------------------------- read path
  // NOTE: io_rdata gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    io_rdata = '0;
    if (!bus.mem_wr) begin
      unique case (sel)
        SEL_DATA: io_rdata = rx_full ? rx_byte : '0;
        SEL_STAT: io_rdata = {{(BYTE_W-2){1'b0}}, rx_full, io_full};
        default:  io_rdata = '0;
      endcase
    end
  end

  // Writes of any kind return zero through the I/O path, so the RAM output is only
  // selected for RAM reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_from_ram <= 1'b0;
      io_q          <= '0;
    end else if (rdy) begin
      dout_from_ram <= (sel == SEL_RAM) && !bus.mem_wr;
      io_q          <= io_rdata;
    end
  end

  assign bus.mem_dout = dout_from_ram ? ram_dout : io_q;
  assign bus.io_full  = io_full;

  // --------------------------------------------------------------- halt
  always_ff @(posedge clk) begin
    if (rst)                                         halt <= 1'b0;
    else if (rdy && (sel == SEL_STAT) && bus.mem_wr) halt <= 1'b1;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a queue/array model.
module tb_mem_io_responder;
  import mem_io_responder_pkg::*;

  localparam int          DEPTH  = 8;
  localparam logic [17:0] A_DATA = 18'h30000;
  localparam logic [17:0] A_STAT = 18'h30004;
  localparam logic [17:0] A_IDLE = 18'h00100;

  logic       clk = 1'b0;
  logic       rst, rdy;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, halt;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halt     (halt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q [$];
  bit         m_rx_full;
  logic [7:0] m_rx_byte;
  bit         m_halt;
  logic [7:0] m_dout;
  bit         m_dout_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit wr, input logic [17:0] a,
                            input logic [7:0] d, input bit tr, input bit rv, input logic [7:0] rd);
    bit old_rx;
    bit old_full;
    bit do_pop;
    int idx;
    old_rx   = m_rx_full;
    old_full = (q.size() == DEPTH);
    if (r) begin
      q.delete();
      m_rx_full    = 0;
      m_halt       = 0;
      m_dout       = 8'h00;
      m_dout_known = 1;
    end else if (en) begin
      do_pop = (q.size() > 0) && tr;
      m_dout_known = 1;
      if (!a[17]) begin
        idx = int'(a[16:0]);
        if (wr) begin
          ram_m[idx] = d;
          m_dout     = 8'h00;
        end else if (ram_m.exists(idx)) begin
          m_dout = ram_m[idx];
        end else begin
          m_dout_known = 0;
        end
      end else if (!a[2]) begin
        if (wr)          m_dout = 8'h00;
        else if (old_rx) begin
          m_dout    = m_rx_byte;
          m_rx_full = 0;
        end else         m_dout = 8'h00;
      end else begin
        if (wr) begin
          m_halt = 1;
          m_dout = 8'h00;
        end else begin
          m_dout = {6'b0, old_rx, old_full};
        end
      end
      if (do_pop) void'(q.pop_front());
      if (a[17] && !a[2] && wr && q.size() < DEPTH) q.push_back(d);
      if (rv && !old_rx) begin
        m_rx_full = 1;
        m_rx_byte = rd;
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit wr, input logic [17:0] a,
                      input logic [7:0] d, input bit tr = 0, input bit rv = 0,
                      input logic [7:0] rd = 8'h00);
    @(negedge clk);
    rst         = r;
    rdy         = en;
    bus.mem_wr  = wr;
    bus.mem_a   = a;
    bus.mem_din = d;
    tx_ready    = tr;
    rx_valid    = rv;
    rx_data     = rd;
    model_step(r, en, wr, a, d, tr, rv, rd);
    @(posedge clk);
    #1;
    if (m_dout_known) check("mem_dout", bus.mem_dout, m_dout);
    check("io_full", bus.io_full, q.size() == DEPTH);
    check("tx_valid", tx_valid, q.size() > 0);
    if (q.size() > 0) check("tx_data", tx_data, q[0]);
    else if (r)       check("tx_data_rst", tx_data, 8'h00);
    check("rx_ready", rx_ready, !m_rx_full);
    check("halt", halt, m_halt);
  endtask

  initial begin
    m_rx_full    = 0;
    m_halt       = 0;
    m_dout       = 8'h00;
    m_dout_known = 0;
    m_rx_byte    = 8'h00;

    step(1, 1, 0, A_IDLE, 8'h00);
    step(1, 0, 0, A_IDLE, 8'h00);

    // Preload the RAM window used by idle reads and random traffic.
    for (int i = 0; i < 16; i++) step(0, 1, 1, A_IDLE + 18'(i), 8'($urandom));

    // Write then stream back four bytes.
    step(0, 1, 1, 18'h00100, 8'h13);
    step(0, 1, 1, 18'h00101, 8'h05);
    step(0, 1, 1, 18'h00102, 8'h10);
    step(0, 1, 1, 18'h00103, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 18'h00100 + 18'(i), 8'h00);
    step(0, 1, 0, A_IDLE, 8'h00);

    // Fill FIFO past capacity, read status, push into full FIFO while popping, drain.
    repeat (9) step(0, 1, 1, A_DATA, 8'h41);
    step(0, 1, 0, A_STAT, 8'h00);
    check("stat_full", bus.mem_dout, 8'h01);
    step(0, 1, 1, A_DATA, 8'h42, 1);
    check("count_kept_full", bus.io_full, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i == 7) check("drain_last", tx_data, 8'h42);
      step(0, 1, 0, A_IDLE, 8'h00, 1);
    end
    check("drained", tx_valid, 1'b0);

    // RX byte path, then read/offer collision.
    step(0, 1, 0, A_IDLE, 8'h00, 0, 1, 8'h5A);
    step(0, 1, 0, A_STAT, 8'h00);
    check("stat_rx", bus.mem_dout, 8'h02);
    step(0, 1, 0, A_DATA, 8'h00);
    check("rx_byte", bus.mem_dout, 8'h5A);
    step(0, 1, 0, A_DATA, 8'h00);
    check("rx_empty", bus.mem_dout, 8'h00);
    step(0, 1, 0, A_IDLE, 8'h00, 0, 1, 8'h11);
    step(0, 1, 0, A_DATA, 8'h00, 0, 1, 8'h22);
    step(0, 1, 0, A_IDLE, 8'h00, 0, 1, 8'h22);
    step(0, 1, 0, A_DATA, 8'h00);

    // rdy low freezes writes, pushes and mem_dout.
    step(0, 1, 1, 18'h00010, 8'h77);
    step(0, 1, 0, 18'h00010, 8'h00);
    step(0, 0, 1, 18'h00010, 8'h99);
    step(0, 0, 1, A_DATA, 8'h55);
    step(0, 1, 0, 18'h00010, 8'h00);
    check("rdy_ram_kept", bus.mem_dout, 8'h77);

    // Sticky halt, then reset with FIFO occupied.
    step(0, 1, 1, A_STAT, 8'hAB);
    repeat (3) step(0, 1, 1, A_DATA, 8'h33);
    step(0, 1, 0, A_IDLE, 8'h00);
    step(1, 1, 0, A_IDLE, 8'h00);
    step(0, 1, 0, A_IDLE, 8'h00);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [17:0] a;
      int          k;
      bit          wr;
      k = $urandom_range(0, 99);
      if (k < 50)      a = A_IDLE + 18'($urandom_range(0, 15));
      else if (k < 78) a = {1'b1, 14'($urandom), 1'b0, 2'($urandom)};
      else             a = {1'b1, 14'($urandom), 1'b1, 2'($urandom)};
      wr = (a[17] && a[2]) ? ($urandom_range(0, 39) == 0) : bit'($urandom_range(0, 1));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, wr, a, 8'($urandom),
           bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
